// File: rtl/softmax_controller_if.sv
// Handshake bundle between the softmax sequencing controller and the input buffer,
// exp unit, adder block and divider around it.
interface softmax_controller_if #(
  parameter int number_of_data = 10
);
  localparam int AW = (number_of_data > 1) ? $clog2(number_of_data) : 1;

  // Strobes are single-cycle and counted only in the cycle their qualifier is high
  // (rd_en_o needs exp_ready_i, div_start_o needs div_ready_i); nothing is held or retried.
  logic          start_i;
  logic          exp_ready_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic          exp_valid_i;
  logic          exp_wr_en_o;
  logic [AW-1:0] exp_wr_addr_o;
  logic          sum_valid_o;
  logic          sum_done_o;
  logic          acc_clear_n_o;
  logic          adder_valid_i;
  logic          div_ready_i;
  logic          div_start_o;
  logic [AW-1:0] div_addr_o;
  logic          div_valid_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [2:0]    state_o;

  modport master (
    input  start_i, exp_ready_i, exp_valid_i, adder_valid_i, div_ready_i, div_valid_i,
    output rd_en_o, rd_addr_o, exp_wr_en_o, exp_wr_addr_o, sum_valid_o, sum_done_o,
           acc_clear_n_o, div_start_o, div_addr_o, busy_o, done_o, err_o, state_o
  );

  modport slave (
    output start_i, exp_ready_i, exp_valid_i, adder_valid_i, div_ready_i, div_valid_i,
    input  rd_en_o, rd_addr_o, exp_wr_en_o, exp_wr_addr_o, sum_valid_o, sum_done_o,
           acc_clear_n_o, div_start_o, div_addr_o, busy_o, done_o, err_o, state_o
  );
endinterface

// File: rtl/softmax_controller.sv
// Sequencer for one softmax pass: exp issue/writeback, adder end-of-exp, divider streaming.
// Optional watchdog compiled in with `define SOFTMAX_CTRL_TIMEOUT_EN.
module softmax_controller #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  softmax_controller_if.master bus
);
  localparam int N  = number_of_data;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  if (N < 1 || data_size < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("softmax_controller: parameters must be positive");
  end

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_EXP      = 3'd2,
    ST_WAIT_SUM = 3'd3,
    ST_DIV      = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, res_cnt_q;
  logic [AW-1:0] rd_addr_q, wr_addr_q, div_addr_q;
  logic          issue_fire, res_fire, timeout;
  logic          rd_en, wr_en, div_start, sum_done, acc_clear_n, done;

  always_comb begin
    state_d     = state_q;
    issue_fire  = 1'b0;
    res_fire    = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    div_start   = 1'b0;
    sum_done    = 1'b0;
    acc_clear_n = 1'b1;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_CLEAR;
      ST_CLEAR: begin
        acc_clear_n = 1'b0;
        state_d     = ST_EXP;
      end
      ST_EXP: begin
        issue_fire = bus.exp_ready_i && (issue_cnt_q < N_C);
        res_fire   = bus.exp_valid_i && (res_cnt_q < N_C);
        rd_en      = issue_fire;
        wr_en      = res_fire;
        if (res_fire && res_cnt_q == LAST_C) state_d = ST_WAIT_SUM;
      end
      ST_WAIT_SUM: begin
        sum_done = 1'b1;
        if (bus.adder_valid_i) state_d = ST_DIV;
      end
      ST_DIV: begin
        issue_fire = bus.div_ready_i && (issue_cnt_q < N_C);
        res_fire   = bus.div_valid_i && (res_cnt_q < N_C);
        div_start  = issue_fire;
        if (res_fire && res_cnt_q == LAST_C) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      div_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      // Both phases reuse the same pair of counters, so they restart on phase entry.
      if (state_d != state_q && (state_d == ST_CLEAR || state_d == ST_DIV)) begin
        issue_cnt_q <= '0;
        res_cnt_q   <= '0;
      end else begin
        if (issue_fire) issue_cnt_q <= issue_cnt_q + 1'b1;
        if (res_fire)   res_cnt_q   <= res_cnt_q + 1'b1;
      end
      if (rd_en)     rd_addr_q  <= issue_cnt_q[AW-1:0];
      if (wr_en)     wr_addr_q  <= res_cnt_q[AW-1:0];
      if (div_start) div_addr_q <= issue_cnt_q[AW-1:0];
    end
  end

`ifdef SOFTMAX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog_q;
  logic          wdog_active, wdog_kick;

  assign wdog_active = (state_q == ST_EXP) || (state_q == ST_WAIT_SUM) || (state_q == ST_DIV);
  assign wdog_kick   = res_fire || (state_q == ST_WAIT_SUM && bus.adder_valid_i);
  assign timeout     = wdog_active && !wdog_kick && (wdog_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wdog_q <= '0;
    end else if (!wdog_active || wdog_kick || state_d != state_q) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Addresses follow the live counter while strobed and hold the last strobed value otherwise.
  assign bus.rd_en_o       = rd_en;
  assign bus.rd_addr_o     = rd_en ? issue_cnt_q[AW-1:0] : rd_addr_q;
  assign bus.exp_wr_en_o   = wr_en;
  assign bus.sum_valid_o   = wr_en;
  assign bus.exp_wr_addr_o = wr_en ? res_cnt_q[AW-1:0] : wr_addr_q;
  assign bus.div_start_o   = div_start;
  assign bus.div_addr_o    = div_start ? issue_cnt_q[AW-1:0] : div_addr_q;
  assign bus.sum_done_o    = sum_done;
  assign bus.acc_clear_n_o = acc_clear_n;
  assign bus.done_o        = done;
  assign bus.err_o         = timeout;
  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.state_o       = state_q;
endmodule

// File: tb/tb_softmax_controller.sv
// Bench for softmax_controller: reactive exp/adder/divider models with an address scoreboard.
module tb_softmax_controller;
  localparam int N  = 10;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
`ifdef SOFTMAX_CTRL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int SUM_WAIT = (TMO > 30) ? 20 : 10;

  logic clock_i = 1'b0;
  logic reset_n_i;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [AW-1:0] exp_rd_q[$], exp_wr_q[$], exp_div_q[$];
  logic [AW-1:0] last_rd = '0, last_wr = '0, last_div = '0;

  always #5 clock_i = ~clock_i;

  softmax_controller_if #(.number_of_data(N)) bus ();
  softmax_controller_if #(.number_of_data(1)) bus1 ();

  softmax_controller #(.data_size(32), .number_of_data(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .bus(bus)
  );
  softmax_controller #(.data_size(32), .number_of_data(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    bus.start_i = 0; bus.exp_ready_i = 0; bus.exp_valid_i = 0;
    bus.adder_valid_i = 0; bus.div_ready_i = 0; bus.div_valid_i = 0;
    bus1.start_i = 0; bus1.exp_ready_i = 0; bus1.exp_valid_i = 0;
    bus1.adder_valid_i = 0; bus1.div_ready_i = 0; bus1.div_valid_i = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_state"}, bus.state_o, 0);
    check({pfx, "_busy"}, bus.busy_o, 0);
    check({pfx, "_rd_en"}, bus.rd_en_o, 0);
    check({pfx, "_rd_addr"}, bus.rd_addr_o, 0);
    check({pfx, "_wr_en"}, bus.exp_wr_en_o, 0);
    check({pfx, "_wr_addr"}, bus.exp_wr_addr_o, 0);
    check({pfx, "_sum_valid"}, bus.sum_valid_o, 0);
    check({pfx, "_sum_done"}, bus.sum_done_o, 0);
    check({pfx, "_acc_clear_n"}, bus.acc_clear_n_o, 1);
    check({pfx, "_div_start"}, bus.div_start_o, 0);
    check({pfx, "_div_addr"}, bus.div_addr_o, 0);
    check({pfx, "_done"}, bus.done_o, 0);
    check({pfx, "_err"}, bus.err_o, 0);
  endtask

  // One full pass of the N-element DUT against a reactive environment.
  task automatic run_pass(input int rdy_mode, input int lat_lo, input int lat_hi,
                          input int stall_at, input int adder_delay, input bit poke,
                          input bit spurious, input int reset_after);
    int exp_due[$];
    int div_due[$];
    int start_cyc, exp_res, div_res, reads, issues, last_due, last_div_due, due;
    int nth_exp_cyc, adder_rise_cyc, div_done_cyc, stall_left;
    bit stalled, in_exp, in_div, genuine, gen_div, spur_now, finished, rdy, drdy;
    logic [AW-1:0] a;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_div_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_rd_q.push_back(AW'(i));
      exp_wr_q.push_back(AW'(i));
      exp_div_q.push_back(AW'(i));
    end
    exp_res = 0; div_res = 0; reads = 0; issues = 0; last_due = 0; last_div_due = 0;
    nth_exp_cyc = -1; adder_rise_cyc = -1; div_done_cyc = -1; stall_left = 0;
    stalled = 0; finished = 0;

    tick();
    drive_idle();
    bus.start_i = 1;
    start_cyc = cyc;
    #1;
    check("idle_before_start", bus.state_o, 0);
    for (int c = 0; c < 600 && !finished; c++) begin
      tick();
      bus.start_i = poke && (cyc == start_cyc + 4 || (adder_rise_cyc >= 0 && cyc == adder_rise_cyc + 2));
      if (reset_after >= 0 && exp_res == reset_after) begin
        bus.start_i = 0; bus.exp_ready_i = 1; bus.exp_valid_i = 0; bus.div_ready_i = 1;
        reset_n_i = 0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        reset_n_i = 1;
        last_rd = '0; last_wr = '0; last_div = '0;
        return;
      end
      in_exp = (cyc >= start_cyc + 2) && (exp_res < N);
      in_div = (adder_rise_cyc >= 0) && (cyc > adder_rise_cyc) && (div_res < N);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = $urandom_range(0, 3) != 0;
      endcase
      bus.exp_ready_i = rdy;
      genuine = (exp_due.size() > 0) && (exp_due[0] <= cyc);
      if (genuine) void'(exp_due.pop_front());
      spur_now = spurious && in_div && (cyc == adder_rise_cyc + 3);
      bus.exp_valid_i = genuine || spur_now;
      bus.adder_valid_i = (adder_rise_cyc >= 0) && (cyc >= adder_rise_cyc);
      if (stall_at >= 0 && !stalled && in_div && issues == stall_at) begin
        stalled = 1;
        stall_left = 5;
      end
      drdy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      bus.div_ready_i = drdy;
      gen_div = (div_due.size() > 0) && (div_due[0] <= cyc);
      if (gen_div) void'(div_due.pop_front());
      bus.div_valid_i = gen_div;
      #1;

      check("rd_en", bus.rd_en_o, in_exp && rdy && reads < N);
      if (bus.rd_en_o) begin
        if (exp_rd_q.size() > 0) begin
          a = exp_rd_q.pop_front();
          check("rd_addr", bus.rd_addr_o, a);
          last_rd = a;
        end
        reads++;
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        exp_due.push_back(due);
        last_due = due;
      end else begin
        check("rd_addr_hold", bus.rd_addr_o, last_rd);
      end

      check("exp_wr_en", bus.exp_wr_en_o, genuine);
      check("sum_valid", bus.sum_valid_o, genuine);
      if (genuine) begin
        a = exp_wr_q.pop_front();
        check("wr_addr", bus.exp_wr_addr_o, a);
        last_wr = a;
        exp_res++;
        if (exp_res == N) begin
          nth_exp_cyc = cyc;
          adder_rise_cyc = cyc + 1 + adder_delay;
        end
      end else begin
        check("wr_addr_hold", bus.exp_wr_addr_o, last_wr);
      end

      if (nth_exp_cyc >= 0 && cyc > nth_exp_cyc && cyc <= adder_rise_cyc) begin
        check("wait_state", bus.state_o, 3);
        check("sum_done", bus.sum_done_o, 1);
      end else begin
        check("sum_done", bus.sum_done_o, 0);
      end

      check("div_start", bus.div_start_o, in_div && drdy && issues < N);
      if (bus.div_start_o) begin
        if (exp_div_q.size() > 0) begin
          a = exp_div_q.pop_front();
          check("div_addr", bus.div_addr_o, a);
          last_div = a;
        end
        issues++;
        if (issues == 1 && stall_at != 0) check("div_first_cyc", cyc, adder_rise_cyc + 1);
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_div_due) due = last_div_due + 1;
        div_due.push_back(due);
        last_div_due = due;
      end else begin
        check("div_addr_hold", bus.div_addr_o, last_div);
      end
      if (gen_div) begin
        div_res++;
        if (div_res == N) div_done_cyc = cyc;
      end

      check("done", bus.done_o, div_done_cyc >= 0 && cyc == div_done_cyc + 1);
      check("acc_clear_n", bus.acc_clear_n_o, cyc != start_cyc + 1);
      check("busy", bus.busy_o, 1);
      check("err", bus.err_o, 0);
      if (div_done_cyc >= 0 && cyc == div_done_cyc + 1) finished = 1;
    end
    check("pass_finished", finished, 1);
    check("reads", reads, N);
    check("issues", issues, N);
    tick();
    drive_idle();
    #1;
    check("back_idle", bus.state_o, 0);
    check("idle_busy", bus.busy_o, 0);
  endtask

  // Smallest configuration: one read, one write, one divide.
  task automatic run_single();
    int rd_cyc, div_cyc, rds, wrs, divs, dones;
    bit saw_sum_done;
    rd_cyc = -100; div_cyc = -100; rds = 0; wrs = 0; divs = 0; dones = 0; saw_sum_done = 0;
    tick();
    drive_idle();
    bus1.start_i = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      bus1.start_i = 0;
      bus1.exp_ready_i = 1;
      bus1.div_ready_i = 1;
      bus1.exp_valid_i = (cyc == rd_cyc + 2);
      bus1.adder_valid_i = saw_sum_done;
      bus1.div_valid_i = (cyc == div_cyc + 2);
      #1;
      if (bus1.rd_en_o) begin rds++; rd_cyc = cyc; check("n1_rd_addr", bus1.rd_addr_o, 0); end
      if (bus1.exp_wr_en_o) begin wrs++; check("n1_wr_addr", bus1.exp_wr_addr_o, 0); end
      if (bus1.div_start_o) begin divs++; div_cyc = cyc; check("n1_div_addr", bus1.div_addr_o, 0); end
      if (bus1.sum_done_o) saw_sum_done = 1;
      if (bus1.done_o) dones++;
    end
    check("n1_reads", rds, 1);
    check("n1_writes", wrs, 1);
    check("n1_divs", divs, 1);
    check("n1_done", dones, 1);
    check("n1_idle", bus1.state_o, 0);
    drive_idle();
  endtask

`ifdef SOFTMAX_CTRL_TIMEOUT_EN
  task automatic run_timeout();
    int due_q[$];
    int exp_res, nth, err_cyc, errs, dones;
    bit genuine;
    exp_res = 0; nth = -1; err_cyc = -1; errs = 0; dones = 0;
    tick();
    drive_idle();
    bus.start_i = 1;
    for (int c = 0; c < 120; c++) begin
      tick();
      bus.start_i = 0;
      bus.exp_ready_i = 1;
      bus.div_ready_i = 1;
      genuine = (due_q.size() > 0) && (due_q[0] <= cyc);
      if (genuine) void'(due_q.pop_front());
      bus.exp_valid_i = genuine;
      #1;
      if (bus.rd_en_o) due_q.push_back(cyc + 2);
      if (genuine) begin
        exp_res++;
        if (exp_res == N) nth = cyc;
      end
      if (bus.err_o) begin
        errs++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (bus.done_o) dones++;
      if (err_cyc >= 0 && cyc == err_cyc + 1) check("tmo_idle", bus.state_o, 0);
    end
    check("tmo_err_cyc", err_cyc - (nth + 1), TMO);
    check("tmo_err_pulses", errs, 1);
    check("tmo_done", dones, 0);
    drive_idle();
  endtask
`endif

  initial begin
    reset_n_i = 0;
    drive_idle();
    repeat (3) tick();
    check_reset_outputs("reset");
    check("reset_n1_state", bus1.state_o, 0);
    reset_n_i = 1;
    tick();

    run_pass(0, 3, 3, -1, 2, 0, 0, -1);          // basic pass
    run_pass(1, 1, 4, 4, 3, 0, 0, -1);           // exp_ready toggling, divider stall
    run_pass(0, 2, 2, -1, SUM_WAIT, 0, 0, -1);   // long sum wait
    run_pass(0, 3, 3, -1, 1, 1, 1, -1);          // stray start and exp_valid
    run_pass(0, 3, 3, -1, 1, 0, 0, 4);           // reset after 4 results
    run_pass(0, 3, 3, -1, 0, 0, 0, -1);          // full pass after reset
    for (int p = 0; p < 5; p++) begin
      run_pass(2, 1, 4, int'($urandom_range(0, N)), int'($urandom_range(0, 8)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    run_single();
`ifdef SOFTMAX_CTRL_TIMEOUT_EN
    run_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
